sysbus_arbiter: RTL and testbench



---
 rtl/sysbus_arbiter.sv | 104 ++++++++++
 tb/tb_sysbus_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: round-robin owner arbitration and request/response mux of NUM_REQ masters onto the main bus.
// Define ARB_TIMEOUT_EN to add a watchdog that forces RELEASE after TIMEOUT_CYCLES response-less OWNED cycles.
module sysbus_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH = 13,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 abtr_reqcyc,
  output logic [NUM_REQ-1:0]                 abtr_grant,
  input  logic [NUM_REQ-1:0]                 bus_busy,
  input  logic [NUM_REQ-1:0]                 m_reqcyc,
  input  logic [NUM_REQ*BUS_DATA_WIDTH-1:0]  m_req,
  input  logic [NUM_REQ*BUS_TAG_WIDTH-1:0]   m_reqtag,
  input  logic [NUM_REQ-1:0]                 m_respack,
  output logic [NUM_REQ-1:0]                 m_respcyc,
  output logic [BUS_DATA_WIDTH-1:0]          m_resp,
  output logic                               main_bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0]          main_bus_req,
  output logic [BUS_TAG_WIDTH-1:0]           main_bus_reqtag,
  input  logic                               main_bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0]          main_bus_resp,
  output logic                               main_bus_respack,
  output logic [$clog2(NUM_REQ)-1:0]         owner,
  output logic                               owner_valid,
  output logic                               timeout_err
);
  localparam int OW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, GRANT, OWNED, RELEASE} state_t;
  state_t state, state_n;
  logic [OW-1:0] last_owner, pick;
  logic found, seen_busy, age, busy, owned, expire;
  logic [NUM_REQ-1:0] sel;
  logic [BUS_DATA_WIDTH-1:0] req_a [NUM_REQ];
  logic [BUS_TAG_WIDTH-1:0] tag_a [NUM_REQ];
  int best;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_a[g] = m_req[g*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
    assign tag_a[g] = m_reqtag[g*BUS_TAG_WIDTH +: BUS_TAG_WIDTH];
  end
  // Winner is the requester at the smallest round-robin distance past last_owner.
  always_comb begin
    pick = last_owner;
    found = 1'b0;
    best = NUM_REQ;
    for (int j = 0; j < NUM_REQ; j++)
      if (abtr_reqcyc[j] && (j - int'(last_owner) - 1 + NUM_REQ) % NUM_REQ < best) begin
        best = (j - int'(last_owner) - 1 + NUM_REQ) % NUM_REQ;
        pick = OW'(j);
        found = 1'b1;
      end
  end
  assign owned = state == OWNED;
  assign busy = bus_busy[owner];
  assign sel = NUM_REQ'(1) << owner;
  // age marks the second OWNED cycle, the last chance for bus_busy to show up.
  always_comb begin
    state_n = state == IDLE  ? (found ? GRANT : IDLE) :
              state == GRANT ? OWNED :
              state == OWNED ? ((expire || (!busy && (seen_busy || age))) ? RELEASE : OWNED) :
                               IDLE;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      owner <= '0;
      last_owner <= OW'(NUM_REQ - 1);
      seen_busy <= 1'b0;
      age <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && found) owner <= pick;
      if (state == RELEASE) last_owner <= owner;
      seen_busy <= owned && (seen_busy || busy);
      age <= owned;
    end
`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tcnt;
  assign expire = owned && !main_bus_respcyc && tcnt == TLAST;
  always_ff @(posedge clk)
    if (reset) begin
      tcnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      tcnt <= (owned && !main_bus_respcyc) ? tcnt + 1'b1 : '0;
      timeout_err <= expire;
    end
`else
  assign expire = 1'b0;
  assign timeout_err = TIMEOUT_CYCLES < 0;
`endif
  assign abtr_grant = state == GRANT ? sel : '0;
  assign owner_valid = state == GRANT || owned;
  assign main_bus_reqcyc = owned && m_reqcyc[owner];
  assign main_bus_req = owned ? req_a[owner] : '0;
  assign main_bus_reqtag = owned ? tag_a[owner] : '0;
  assign main_bus_respack = owned && m_respack[owner];
  assign m_respcyc = (owned && main_bus_respcyc) ? sel : '0;
  assign m_resp = owned ? main_bus_resp : '0;
endmodule

// File: tb/tb_sysbus_arbiter.sv
// tb_sysbus_arbiter: directed and random stimulus against a cycle-level behavioural model of the bus arbiter.
module tb_sysbus_arbiter;
  localparam int N = 2, W = 64, TW = 13, TO = 16;
  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0] abtr_reqcyc, abtr_grant, bus_busy, m_reqcyc, m_respack, m_respcyc;
  logic [W-1:0] req_v [N];
  logic [TW-1:0] tag_v [N];
  logic [N*W-1:0] m_req;
  logic [N*TW-1:0] m_reqtag;
  logic [W-1:0] m_resp, main_bus_req, main_bus_resp;
  logic [TW-1:0] main_bus_reqtag;
  logic main_bus_reqcyc, main_bus_respcyc, main_bus_respack, owner_valid, timeout_err;
  logic [0:0] owner;
  int checks = 0, errors = 0;
  bit started = 1'b0;
  assign m_req = {req_v[1], req_v[0]};
  assign m_reqtag = {tag_v[1], tag_v[0]};
  always #5 clk = ~clk;

  sysbus_arbiter #(.NUM_REQ(N), .BUS_DATA_WIDTH(W), .BUS_TAG_WIDTH(TW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .abtr_reqcyc(abtr_reqcyc), .abtr_grant(abtr_grant), .bus_busy(bus_busy),
    .m_reqcyc(m_reqcyc), .m_req(m_req), .m_reqtag(m_reqtag), .m_respack(m_respack), .m_respcyc(m_respcyc),
    .m_resp(m_resp), .main_bus_reqcyc(main_bus_reqcyc), .main_bus_req(main_bus_req),
    .main_bus_reqtag(main_bus_reqtag), .main_bus_respcyc(main_bus_respcyc), .main_bus_resp(main_bus_resp),
    .main_bus_respack(main_bus_respack), .owner(owner), .owner_valid(owner_valid), .timeout_err(timeout_err));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    abtr_reqcyc = '0; bus_busy = '0; m_reqcyc = '0; m_respack = '0;
    main_bus_respcyc = 1'b0; main_bus_resp = '0;
    for (int i = 0; i < N; i++) begin req_v[i] = '0; tag_v[i] = '0; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_in();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_grant(input string nm);
    bit got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      @(negedge clk);
      got = abtr_grant != '0;
      if (!got) tick();
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s no grant within 12 cycles", nm);
    end
  endtask

  // Reference model: who owns the bus and for how long, derived from the handshake rules.
  initial begin : model
    int mo, age, last, own, tc, mi;
    bit saw, rel, terr, ow, ended, to, b;
    mo = -1; age = 0; last = N - 1; own = 0; tc = 0; saw = 0; rel = 0; terr = 0;
    forever begin
      @(negedge clk);
      if (started) begin
        mi = mo < 0 ? 0 : mo;
        ow = mo >= 0 && age >= 1;
        chk("grant", abtr_grant, (mo >= 0 && age == 0) ? (1 << mo) : 0);
        chk("owner_valid", owner_valid, mo >= 0);
        chk("owner", owner, own);
        chk("bus_reqcyc", main_bus_reqcyc, ow && m_reqcyc[mi]);
        chk("bus_req", main_bus_req, ow ? req_v[mi] : 0);
        chk("bus_reqtag", main_bus_reqtag, ow ? tag_v[mi] : 0);
        chk("bus_respack", main_bus_respack, ow && m_respack[mi]);
        chk("m_respcyc", m_respcyc, (ow && main_bus_respcyc) ? (1 << mi) : 0);
        chk("m_resp", m_resp, ow ? main_bus_resp : 0);
        chk("timeout_err", timeout_err, terr);
      end
      @(posedge clk);
      if (reset) begin
        mo = -1; rel = 0; last = N - 1; own = 0; saw = 0; tc = 0; terr = 0; started = 1;
      end else if (started) begin
        terr = 0;
        if (rel) begin
          rel = 0;
          last = own;
        end else if (mo < 0) begin
          for (int i = 1; i <= N; i++)
            if (mo < 0 && abtr_reqcyc[(last + i) % N]) begin
              mo = (last + i) % N; own = mo; age = 0;
            end
        end else if (age == 0) begin
          age = 1; saw = 0; tc = 0;
        end else begin
          b = bus_busy[mo];
          to = 0;
`ifdef ARB_TIMEOUT_EN
          if (main_bus_respcyc) tc = 0;
          else if (tc == TO - 1) to = 1;
          else tc++;
`endif
          ended = to || (!b && (saw || age == 2));
          saw = saw || b;
          age++;
          if (ended) begin mo = -1; rel = 1; terr = to; end
        end
      end
    end
  end

  initial begin
    int gt [4];
    logic [N-1:0] gv [4];
    int ng, n;
    bit got;
    clear_in();
    repeat (3) tick();
    reset = 1'b0;
    // First ownership after reset goes to master 0.
    @(negedge clk);
    chk("rst_valid", owner_valid, 1'b0);
    chk("rst_grant", abtr_grant, 2'b00);
    chk("rst_owner", owner, 1'b0);
    tick();
    abtr_reqcyc = 2'b01;
    @(negedge clk);
    chk("idle_grant", abtr_grant, 2'b00);
    tick();
    abtr_reqcyc = 2'b00;
    @(negedge clk);
    chk("first_grant", abtr_grant, 2'b01);
    chk("first_valid", owner_valid, 1'b1);
    chk("grant_reqcyc", main_bus_reqcyc, 1'b0);
    tick();
    m_reqcyc = 2'b01; req_v[0] = 64'hA5A5_0000_1234_5678; tag_v[0] = 13'h0AB; bus_busy = 2'b01;
    req_v[1] = 64'hDEAD_BEEF_0000_0001; tag_v[1] = 13'h1FF;
    @(negedge clk);
    chk("owned_req", main_bus_req, 64'hA5A5_0000_1234_5678);
    chk("owned_tag", main_bus_reqtag, 13'h0AB);
    chk("owned_reqcyc", main_bus_reqcyc, 1'b1);
    tick();
    bus_busy = 2'b00; m_reqcyc = 2'b00;
    @(negedge clk);
    chk("busy_fall_valid", owner_valid, 1'b1);
    tick();
    @(negedge clk);
    chk("release_valid", owner_valid, 1'b0);
    tick();

    // Both request forever, nobody raises busy: alternate owners, abandoned after 2 OWNED cycles.
    do_reset();
    abtr_reqcyc = 2'b11;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      @(negedge clk);
      if (abtr_grant != '0) begin gv[ng] = abtr_grant; gt[ng] = c; ng++; end
      tick();
    end
    chk("rr_count", ng, 4);
    for (int i = 0; i < ng; i++) chk("rr_order", gv[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    for (int i = 1; i < ng; i++) chk("rr_gap", gt[i] - gt[i-1], 5);
    abtr_reqcyc = 2'b00;

    // Master 1 takes an 8-beat response burst.
    do_reset();
    abtr_reqcyc = 2'b10;
    wait_grant("burst_grant_wait");
    chk("burst_grant", abtr_grant, 2'b10);
    tick();
    abtr_reqcyc = 2'b00; bus_busy = 2'b10;
    for (int i = 0; i < 8; i++) begin
      main_bus_respcyc = 1'b1; main_bus_resp = 64'h10 + 64'(i); m_respack = {i[0], ~i[0]};
      @(negedge clk);
      chk("beat_respcyc", m_respcyc, 2'b10);
      chk("beat_resp", m_resp, 64'h10 + 64'(i));
      chk("beat_respack", main_bus_respack, i[0]);
      tick();
    end
    clear_in();
    repeat (3) tick();

    // Reset mid-ownership drops everything at the next edge.
    do_reset();
    abtr_reqcyc = 2'b01;
    wait_grant("abort_grant_wait");
    tick();
    abtr_reqcyc = 2'b00; bus_busy = 2'b01; m_reqcyc = 2'b01; m_respack = 2'b01; main_bus_respcyc = 1'b1;
    @(negedge clk);
    chk("abort_pre_reqcyc", main_bus_reqcyc, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("abort_reqcyc", main_bus_reqcyc, 1'b0);
    chk("abort_respack", main_bus_respack, 1'b0);
    chk("abort_valid", owner_valid, 1'b0);
    chk("abort_grant", abtr_grant, 2'b00);
    tick();
    reset = 1'b0;
    clear_in();

`ifdef ARB_TIMEOUT_EN
    // Busy held with no responses: watchdog fires after TO OWNED cycles.
    do_reset();
    abtr_reqcyc = 2'b01;
    wait_grant("to_grant_wait");
    tick();
    abtr_reqcyc = 2'b00; bus_busy = 2'b01;
    n = 0; got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (timeout_err) got = 1'b1;
      else begin
        if (owner_valid) n++;
        tick();
      end
    end
    chk("to_fired", got, 1'b1);
    chk("to_owned_cycles", n, TO);
    tick();
    clear_in();
    repeat (2) tick();
`endif

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tick();
      abtr_reqcyc = N'($urandom);
      for (int i = 0; i < N; i++) begin
        bus_busy[i] = $urandom_range(0, 9) < 6;
        req_v[i] = {$urandom, $urandom};
        tag_v[i] = TW'($urandom);
      end
      m_reqcyc = N'($urandom);
      m_respack = N'($urandom);
      main_bus_respcyc = $urandom_range(0, 3) == 0;
      main_bus_resp = {$urandom, $urandom};
      reset = $urandom_range(0, 499) == 0;
    end
    tick();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
